// File: rtl/axis_pattern_sequencer.sv
// Test-pattern sequencer: drives the AXI4-Stream pattern generator's enable/select and
// monitors its output handshake to count frames and flag line-length / frame-height errors.
module axis_pattern_sequencer #(
    parameter int          H_ACTIVE           = 960,
    parameter int          V_ACTIVE           = 2160,
    parameter int          FRAMES_PER_PATTERN = 4,
    parameter logic [7:0]  PATTERN_MASK       = 8'hFF,
    parameter int          SETTLE_CYCLES      = 4
) (
    input  logic        sys_clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        auto_i,
    input  logic [2:0]  manual_sel_i,
    input  logic        mon_tvalid_i,
    input  logic        mon_tready_i,
    input  logic        mon_tuser_i,
    input  logic        mon_tlast_i,
    output logic        gen_en_o,
    output logic [2:0]  pattern_sel_o,
    output logic        pattern_change_o,
    output logic [15:0] frame_count_o,
    output logic        pix_err_o,
    output logic        line_err_o,
    output logic [1:0]  state_o
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_SOF = 2'd1;
    localparam logic [1:0] ST_ACTIVE   = 2'd2;
    localparam logic [1:0] ST_SWITCH   = 2'd3;

    // An empty rotation would leave nothing to play, so it falls back to pattern 0.
    localparam logic [7:0]  EFF_MASK    = (PATTERN_MASK == 8'h00) ? 8'h01 : PATTERN_MASK;
    localparam logic [15:0] H_LEN       = 16'(H_ACTIVE);
    localparam logic [15:0] LAST_LINE   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] FPP         = 16'(FRAMES_PER_PATTERN);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        logic [15:0] r;
        r = (v == 16'hFFFF) ? v : (v + 16'd1);
        return r;
    endfunction

    function automatic logic [2:0] first_pattern(input logic [7:0] mask);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                r = 3'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Searches cur+1 .. cur+7 (mod 8); returns cur when no other bit is set.
    function automatic logic [2:0] next_pattern(input logic [7:0] mask, input logic [2:0] cur);
        logic [2:0] r;
        logic [2:0] idx;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int k = 1; k < 8; k++) begin
            idx = cur + 3'(k);
            if (!found && mask[idx]) begin
                r     = idx;
                found = 1'b1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [1:0]  state_q, state_d;
    logic        gen_en_q, gen_en_d;
    logic [2:0]  pattern_sel_q, pattern_sel_d;
    logic        pattern_change_q, pattern_change_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        pix_err_q, pix_err_d;
    logic        line_err_q, line_err_d;
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic [15:0] line_cnt_q, line_cnt_d;
    logic [15:0] frames_in_pat_q, frames_in_pat_d;
    logic [15:0] settle_cnt_q, settle_cnt_d;

    logic        beat_s;
    logic        track_s;
    logic [15:0] pix_len_s;
    logic [15:0] line_base_s;
    logic [15:0] frames_inc_s;
    logic [2:0]  start_sel_s;
    logic [2:0]  auto_next_s;

    // Next-state, pattern selection and stream-monitor counters.
    always_comb begin
        state_d          = state_q;
        pattern_sel_d    = pattern_sel_q;
        pattern_change_d = 1'b0;
        frame_count_d    = frame_count_q;
        pix_err_d        = pix_err_q;
        line_err_d       = line_err_q;
        pix_cnt_d        = pix_cnt_q;
        line_cnt_d       = line_cnt_q;
        frames_in_pat_d  = frames_in_pat_q;
        settle_cnt_d     = settle_cnt_q;
        track_s          = 1'b0;

        beat_s       = mon_tvalid_i & mon_tready_i;
        // A SOF beat restarts the frame with itself as pixel 0 of line 0.
        pix_len_s    = mon_tuser_i ? 16'd1 : sat_inc(pix_cnt_q);
        line_base_s  = mon_tuser_i ? 16'd0 : line_cnt_q;
        frames_inc_s = sat_inc(frames_in_pat_q);
        start_sel_s  = auto_i ? first_pattern(EFF_MASK) : manual_sel_i;
        auto_next_s  = next_pattern(EFF_MASK, pattern_sel_q);

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    pattern_sel_d    = start_sel_s;
                    pattern_change_d = (start_sel_s != pattern_sel_q);
                    frames_in_pat_d  = 16'd0;
                    state_d          = ST_WAIT_SOF;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_SOF: begin
                // No frame is in flight here, so a dropped enable stops at once.
                if (beat_s && mon_tuser_i) begin
                    track_s = 1'b1;
                end else if (!enable_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_SOF;
                end
            end
            ST_ACTIVE: begin
                if (beat_s) begin
                    track_s    = 1'b1;
                    line_err_d = line_err_q | mon_tuser_i;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_SWITCH: begin
                if (settle_cnt_q >= SETTLE_LAST) begin
                    settle_cnt_d = 16'd0;
                    state_d      = ST_WAIT_SOF;
                end else begin
                    settle_cnt_d = settle_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (track_s) begin
            state_d = ST_ACTIVE;
            if (mon_tlast_i) begin
                pix_err_d  = pix_err_q | (pix_len_s != H_LEN);
                pix_cnt_d  = 16'd0;
                line_cnt_d = sat_inc(line_base_s);
                if (line_base_s == LAST_LINE) begin
                    frame_count_d   = frame_count_q + 16'd1;
                    frames_in_pat_d = frames_inc_s;
                    settle_cnt_d    = 16'd0;
                    if (!enable_i) begin
                        state_d = ST_IDLE;
                    end else if (auto_i && (frames_inc_s >= FPP)) begin
                        frames_in_pat_d = 16'd0;
                        if (auto_next_s != pattern_sel_q) begin
                            pattern_sel_d    = auto_next_s;
                            pattern_change_d = 1'b1;
                            state_d          = ST_SWITCH;
                        end else begin
                            state_d = ST_WAIT_SOF;
                        end
                    end else if (!auto_i && (manual_sel_i != pattern_sel_q)) begin
                        pattern_sel_d    = manual_sel_i;
                        pattern_change_d = 1'b1;
                        frames_in_pat_d  = 16'd0;
                        state_d          = ST_SWITCH;
                    end else begin
                        state_d = ST_WAIT_SOF;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end else begin
                pix_cnt_d  = pix_len_s;
                line_cnt_d = line_base_s;
            end
        end else begin
            track_s = 1'b0;
        end

        gen_en_d = (state_d == ST_WAIT_SOF) || (state_d == ST_ACTIVE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge sys_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q          <= ST_IDLE;
            gen_en_q         <= 1'b0;
            pattern_sel_q    <= 3'd0;
            pattern_change_q <= 1'b0;
            frame_count_q    <= 16'd0;
            pix_err_q        <= 1'b0;
            line_err_q       <= 1'b0;
            pix_cnt_q        <= 16'd0;
            line_cnt_q       <= 16'd0;
            frames_in_pat_q  <= 16'd0;
            settle_cnt_q     <= 16'd0;
        end else begin
            state_q          <= state_d;
            gen_en_q         <= gen_en_d;
            pattern_sel_q    <= pattern_sel_d;
            pattern_change_q <= pattern_change_d;
            frame_count_q    <= frame_count_d;
            pix_err_q        <= pix_err_d;
            line_err_q       <= line_err_d;
            pix_cnt_q        <= pix_cnt_d;
            line_cnt_q       <= line_cnt_d;
            frames_in_pat_q  <= frames_in_pat_d;
            settle_cnt_q     <= settle_cnt_d;
        end
    end

    assign gen_en_o         = gen_en_q;
    assign pattern_sel_o    = pattern_sel_q;
    assign pattern_change_o = pattern_change_q;
    assign frame_count_o    = frame_count_q;
    assign pix_err_o        = pix_err_q;
    assign line_err_o       = line_err_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_axis_pattern_sequencer.sv
// Directed bench for axis_pattern_sequencer with 8x4 frames, 2 frames per pattern, mask 8'hA5.
module tb_axis_pattern_sequencer;

    logic        sys_clk_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        auto_i;
    logic [2:0]  manual_sel_i;
    logic        mon_tvalid_i;
    logic        mon_tready_i;
    logic        mon_tuser_i;
    logic        mon_tlast_i;
    logic        gen_en_o;
    logic [2:0]  pattern_sel_o;
    logic        pattern_change_o;
    logic [15:0] frame_count_o;
    logic        pix_err_o;
    logic        line_err_o;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;
    int low_cnt = 0;
    int chg_cnt = 0;
    bit mon_on = 1'b0;
    bit bp = 1'b0;
    logic [2:0] rot [5] = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0};

    always #5 sys_clk_i = ~sys_clk_i;

    axis_pattern_sequencer #(
        .H_ACTIVE(8), .V_ACTIVE(4), .FRAMES_PER_PATTERN(2),
        .PATTERN_MASK(8'hA5), .SETTLE_CYCLES(4)
    ) dut (
        .sys_clk_i(sys_clk_i), .reset_i(reset_i), .enable_i(enable_i), .auto_i(auto_i),
        .manual_sel_i(manual_sel_i), .mon_tvalid_i(mon_tvalid_i), .mon_tready_i(mon_tready_i),
        .mon_tuser_i(mon_tuser_i), .mon_tlast_i(mon_tlast_i), .gen_en_o(gen_en_o),
        .pattern_sel_o(pattern_sel_o), .pattern_change_o(pattern_change_o),
        .frame_count_o(frame_count_o), .pix_err_o(pix_err_o), .line_err_o(line_err_o),
        .state_o(state_o)
    );

    // Counts generator-disabled cycles and change pulses during the auto rotation.
    always @(negedge sys_clk_i) begin
        if (mon_on) begin
            if (gen_en_o == 1'b0) low_cnt <= low_cnt + 1;
            if (pattern_change_o == 1'b1) chg_cnt <= chg_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic u, input logic l);
        mon_tvalid_i = 1'b1;
        mon_tuser_i  = u;
        mon_tlast_i  = l;
        if (bp) begin
            mon_tready_i = 1'b0;
            tick();
        end
        mon_tready_i = 1'b1;
        tick();
        mon_tvalid_i = bp;
        mon_tuser_i  = 1'b0;
        mon_tlast_i  = 1'b0;
    endtask

    task automatic send_line(input logic sof, input int len);
        for (int i = 0; i < len; i++) send_beat(sof && (i == 0), i == len - 1);
    endtask

    task automatic send_frame();
        send_line(1'b1, 8);
        for (int j = 0; j < 3; j++) send_line(1'b0, 8);
    endtask

    task automatic wait_gen_en(input string tag);
        for (int i = 0; i < 50 && gen_en_o !== 1'b1; i++) tick();
        chk(tag, 32'(gen_en_o), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b0; enable_i = 1'b0; auto_i = 1'b0; manual_sel_i = 3'd0;
        mon_tvalid_i = 1'b0; mon_tready_i = 1'b1; mon_tuser_i = 1'b0; mon_tlast_i = 1'b0;
        tick(); tick(); tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_gen_en", 32'(gen_en_o), 32'd0);
        chk("rst_sel", 32'(pattern_sel_o), 32'd0);
        chk("rst_change", 32'(pattern_change_o), 32'd0);
        chk("rst_fc", 32'(frame_count_o), 32'd0);
        chk("rst_pix_err", 32'(pix_err_o), 32'd0);
        chk("rst_line_err", 32'(line_err_o), 32'd0);
        reset_i = 1'b1;
        tick();
        chk("idle_hold", 32'(state_o), 32'd0);

        // Auto rotation 0,2,5,7,0.
        enable_i = 1'b1; auto_i = 1'b1;
        tick();
        chk("start_state", 32'(state_o), 32'd1);
        chk("start_gen_en", 32'(gen_en_o), 32'd1);
        chk("start_sel", 32'(pattern_sel_o), 32'd0);
        chk("start_change", 32'(pattern_change_o), 32'd0);
        mon_on = 1'b1;
        for (int f = 0; f < 8; f++) begin
            wait_gen_en("auto_gen_en");
            send_frame();
            chk("auto_sel", 32'(pattern_sel_o), 32'(rot[(f + 1) / 2]));
            if (f % 2 == 1) begin
                chk("auto_switch_state", 32'(state_o), 32'd3);
                chk("auto_change_pulse", 32'(pattern_change_o), 32'd1);
            end
        end
        wait_gen_en("auto_end_gen_en");
        mon_on = 1'b0;
        chk("auto_low_cycles", 32'(low_cnt), 32'd16);
        chk("auto_change_count", 32'(chg_cnt), 32'd4);
        chk("auto_fc", 32'(frame_count_o), 32'd8);
        chk("auto_pix_err", 32'(pix_err_o), 32'd0);
        chk("auto_line_err", 32'(line_err_o), 32'd0);

        // Manual select, with a mid-frame change.
        auto_i = 1'b0; manual_sel_i = 3'd3;
        send_frame();
        chk("man_sel3", 32'(pattern_sel_o), 32'd3);
        chk("man_fc9", 32'(frame_count_o), 32'd9);
        wait_gen_en("man_gen_en");
        send_line(1'b1, 8);
        send_line(1'b0, 8);
        manual_sel_i = 3'd6;
        send_line(1'b0, 8);
        chk("man_sel_hold", 32'(pattern_sel_o), 32'd3);
        send_line(1'b0, 8);
        chk("man_sel6", 32'(pattern_sel_o), 32'd6);
        chk("man_change", 32'(pattern_change_o), 32'd1);
        chk("man_fc10", 32'(frame_count_o), 32'd10);

        // Backpressure: tready toggling with tvalid held.
        wait_gen_en("bp_gen_en");
        bp = 1'b1;
        send_frame();
        send_frame();
        bp = 1'b0;
        mon_tvalid_i = 1'b0;
        chk("bp_fc", 32'(frame_count_o), 32'd12);
        chk("bp_state", 32'(state_o), 32'd1);
        chk("bp_pix_err", 32'(pix_err_o), 32'd0);
        chk("bp_line_err", 32'(line_err_o), 32'd0);

        // Short line.
        send_line(1'b1, 8);
        send_line(1'b0, 7);
        send_line(1'b0, 8);
        send_line(1'b0, 8);
        chk("bad_pix_err", 32'(pix_err_o), 32'd1);
        chk("bad_line_err", 32'(line_err_o), 32'd0);
        chk("bad_fc", 32'(frame_count_o), 32'd13);
        send_frame();
        chk("bad_pix_sticky", 32'(pix_err_o), 32'd1);
        chk("bad_fc_next", 32'(frame_count_o), 32'd14);

        // Early SOF after two lines restarts the frame.
        send_line(1'b1, 8);
        send_line(1'b0, 8);
        chk("esof_pre_line_err", 32'(line_err_o), 32'd0);
        send_beat(1'b1, 1'b0);
        chk("esof_line_err", 32'(line_err_o), 32'd1);
        for (int i = 0; i < 7; i++) send_beat(1'b0, i == 6);
        for (int j = 0; j < 3; j++) send_line(1'b0, 8);
        chk("esof_fc", 32'(frame_count_o), 32'd15);
        chk("esof_sticky", 32'(line_err_o), 32'd1);

        // Graceful stop mid-frame.
        send_line(1'b1, 8);
        send_line(1'b0, 8);
        enable_i = 1'b0;
        send_line(1'b0, 8);
        chk("stop_active", 32'(state_o), 32'd2);
        chk("stop_gen_en_on", 32'(gen_en_o), 32'd1);
        send_line(1'b0, 8);
        chk("stop_idle", 32'(state_o), 32'd0);
        chk("stop_gen_en_off", 32'(gen_en_o), 32'd0);
        chk("stop_fc", 32'(frame_count_o), 32'd16);
        tick();
        chk("stop_idle_hold", 32'(state_o), 32'd0);

        // Asynchronous reset mid-frame.
        enable_i = 1'b1;
        tick();
        chk("rs_wait", 32'(state_o), 32'd1);
        send_line(1'b1, 8);
        send_line(1'b0, 8);
        #2 reset_i = 1'b0;
        #1;
        chk("rs_state", 32'(state_o), 32'd0);
        chk("rs_gen_en", 32'(gen_en_o), 32'd0);
        chk("rs_sel", 32'(pattern_sel_o), 32'd0);
        chk("rs_change", 32'(pattern_change_o), 32'd0);
        chk("rs_fc", 32'(frame_count_o), 32'd0);
        chk("rs_pix_err", 32'(pix_err_o), 32'd0);
        chk("rs_line_err", 32'(line_err_o), 32'd0);
        tick();
        reset_i = 1'b1;
        tick();
        chk("rs_restart_state", 32'(state_o), 32'd1);
        chk("rs_restart_sel", 32'(pattern_sel_o), 32'd6);
        chk("rs_restart_change", 32'(pattern_change_o), 32'd1);
        send_frame();
        chk("rs_restart_fc", 32'(frame_count_o), 32'd1);
        chk("rs_restart_pix", 32'(pix_err_o), 32'd0);
        chk("rs_restart_line", 32'(line_err_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
